// File: rtl/boot_rom_shadow_loader.sv
// Boot pROM to RAM shadow copier: holds the CPU in reset while ROM words are copied to the top of memory.
// Optional running checksum of written words is enabled with `define BOOT_ROM_CKSUM_EN.
module boot_rom_shadow_loader #(
  parameter int              ROM_AW    = 10,
  parameter int              NWORDS    = 1024,
  parameter int              DAW       = 18,
  parameter logic [DAW-1:0]  DEST_BASE = 18'h3FC00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ROM_AW-1:0] rom_ad,
  input  logic [31:0]       rom_dout,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [DAW-1:0]    mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done
`ifdef BOOT_ROM_CKSUM_EN
  ,
  output logic [31:0]       cksum
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [ROM_AW-1:0] LAST = ROM_AW'(NWORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [ROM_AW-1:0] index;
  logic              accepted;

  assign accepted  = (state == ST_WR) && mem_ack;
  assign rom_ce    = (state == ST_RD);
  assign rom_oce   = rom_ce;
  assign rom_reset = reset;
  assign rom_ad    = index;

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: next_state = ST_RD;
      ST_RD:   next_state = ST_CAP;
      ST_CAP:  next_state = ST_WR;
      ST_WR:   if (mem_ack) next_state = (index == LAST) ? ST_DONE : ST_RD;
      ST_DONE: if (reload) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= DEST_BASE;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
    end else begin
      state <= next_state;
      // ROM data is valid in CAP; launch the write request with it
      if (state == ST_CAP) begin
        mem_wdata <= rom_dout;
        mem_addr  <= DEST_BASE + DAW'(index);
        mem_req   <= 1'b1;
      end
      // Write accepted; the index saturates at the last word
      if (accepted) begin
        mem_req <= 1'b0;
        if (index == LAST) begin
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end else begin
          index <= index + 1'b1;
        end
      end
      if ((state == ST_DONE) && reload) begin
        done    <= 1'b0;
        cpu_rst <= 1'b1;
        index   <= '0;
      end
    end
  end

`ifdef BOOT_ROM_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cksum <= '0;
    end else if ((state == ST_DONE) && reload) begin
      cksum <= '0;
    end else if (accepted) begin
      cksum <= cksum + mem_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_boot_rom_shadow_loader.sv
// Self-checking bench for boot_rom_shadow_loader: reset/step vector table, full copy runs against
// a write-sequence model, stalls, reload, mid-copy reset, a single-word instance, optional checksum.
module tb_boot_rom_shadow_loader;
  localparam int         N    = 1024;
  localparam logic [17:0] BASE = 18'h3FC00;
  localparam logic       H    = 1'b1;
  localparam logic       L    = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [N];

  // Instance A: default parameters
  logic        reset_a = 1'b1, reload_a = 1'b0, mem_ack_a = 1'b0;
  logic        rom_ce_a, rom_oce_a, rom_reset_a, mem_req_a, cpu_rst_a, done_a;
  logic [9:0]  rom_ad_a;
  logic [31:0] rom_dout_a = '0;
  logic [17:0] mem_addr_a;
  logic [31:0] mem_wdata_a;
`ifdef BOOT_ROM_CKSUM_EN
  logic [31:0] cksum_a;
`endif

  // Instance B: single word at the very top of memory
  logic        reset_b = 1'b1, reload_b = 1'b0, mem_ack_b = 1'b1;
  logic        rom_ce_b, rom_oce_b, rom_reset_b, mem_req_b, cpu_rst_b, done_b;
  logic [9:0]  rom_ad_b;
  logic [31:0] rom_dout_b = '0;
  logic [17:0] mem_addr_b;
  logic [31:0] mem_wdata_b;
`ifdef BOOT_ROM_CKSUM_EN
  logic [31:0] cksum_b;
  logic        rom_ce_c, rom_oce_c, rom_reset_c, mem_req_c, cpu_rst_c, done_c;
  logic [9:0]  rom_ad_c;
  logic [31:0] rom_dout_c = '0;
  logic [17:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic [31:0] cksum_c;
`endif

  always @(posedge clk) if (rom_ce_a) rom_dout_a <= rom[rom_ad_a];
  always @(posedge clk) if (rom_ce_b) rom_dout_b <= rom[rom_ad_b];

  boot_rom_shadow_loader dut_a (
    .clk(clk), .reset(reset_a), .reload(reload_a),
    .rom_ce(rom_ce_a), .rom_oce(rom_oce_a), .rom_reset(rom_reset_a), .rom_ad(rom_ad_a),
    .rom_dout(rom_dout_a), .mem_req(mem_req_a), .mem_ack(mem_ack_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .cpu_rst(cpu_rst_a), .done(done_a)
`ifdef BOOT_ROM_CKSUM_EN
    , .cksum(cksum_a)
`endif
  );

  boot_rom_shadow_loader #(.NWORDS(1), .DEST_BASE(18'h3FFFF)) dut_b (
    .clk(clk), .reset(reset_b), .reload(reload_b),
    .rom_ce(rom_ce_b), .rom_oce(rom_oce_b), .rom_reset(rom_reset_b), .rom_ad(rom_ad_b),
    .rom_dout(rom_dout_b), .mem_req(mem_req_b), .mem_ack(mem_ack_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .cpu_rst(cpu_rst_b), .done(done_b)
`ifdef BOOT_ROM_CKSUM_EN
    , .cksum(cksum_b)
`endif
  );

`ifdef BOOT_ROM_CKSUM_EN
  always @(posedge clk) if (rom_ce_c) rom_dout_c <= rom[rom_ad_c];

  boot_rom_shadow_loader #(.NWORDS(2)) dut_c (
    .clk(clk), .reset(reset_b), .reload(reload_b),
    .rom_ce(rom_ce_c), .rom_oce(rom_oce_c), .rom_reset(rom_reset_c), .rom_ad(rom_ad_c),
    .rom_dout(rom_dout_c), .mem_req(mem_req_c), .mem_ack(mem_ack_b), .mem_addr(mem_addr_c),
    .mem_wdata(mem_wdata_c), .cpu_rst(cpu_rst_c), .done(done_c), .cksum(cksum_c)
  );
`endif

  typedef struct {
    logic        rst, rld, ack;
    logic        ce, req, crst, dn;
    logic [9:0]  ad;
    logic [17:0] addr;
    logic        wchk;
    logic [31:0] wd;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs instance A from cycle 0 (IDLE, reset low) until done, modelling the expected write stream.
  task automatic run_copy(input string tag, input int stall_word, input int stall_len,
                          input int reload_word, input bit rand_ack,
                          output int cycles, output int stalls);
    int n = 0, ce_pulses = 0, wr_cnt = 0, seq_bad = 0, stable_bad = 0, crst_bad = 0;
    int stall_left = stall_len, idx;
    bit reload_sent = 0;
    logic [17:0] diff, sa = '0;
    logic [31:0] sd = '0;
    stalls = 0;
    while (n < 8000) begin
      if (rom_ce_a) ce_pulses++;
      if (!cpu_rst_a) crst_bad++;
      reload_a = 1'b0;
      if (mem_req_a) begin
        diff = mem_addr_a - BASE;
        idx  = int'(diff);
        if (idx == stall_word && stall_left > 0) begin
          if (stall_left < stall_len && (mem_addr_a !== sa || mem_wdata_a !== sd)) stable_bad++;
          if (rom_ce_a) stable_bad++;
          sa = mem_addr_a;
          sd = mem_wdata_a;
          stall_left--;
          mem_ack_a = 1'b0;
        end else begin
          mem_ack_a = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (idx == reload_word && !reload_sent) begin
          reload_a = 1'b1;
          reload_sent = 1;
        end
        if (!mem_ack_a) stalls++;
        else begin
          if (wr_cnt >= N || mem_addr_a !== BASE + 18'(wr_cnt) || mem_wdata_a !== rom[wr_cnt]) begin
            if (seq_bad == 0)
              $display("%s: write %0d at %0h data %0h", tag, wr_cnt, mem_addr_a, mem_wdata_a);
            seq_bad++;
          end
          wr_cnt++;
        end
      end else begin
        mem_ack_a = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      n++;
      if (done_a) break;
    end
    reload_a  = 1'b0;
    mem_ack_a = 1'b1;
    chk({tag, ".done_cycle"}, n, 3 * N + 1 + stalls);
    chk({tag, ".cpu_rst_at_done"}, cpu_rst_a, 0);
    chk({tag, ".cpu_rst_held"}, crst_bad, 0);
    chk({tag, ".write_count"}, wr_cnt, N);
    chk({tag, ".write_seq_errors"}, seq_bad, 0);
    chk({tag, ".rom_reads"}, ce_pulses, N);
    if (stall_len > 0) chk({tag, ".stall_stability_errors"}, stable_bad, 0);
    repeat (3) tick();
    chk({tag, ".idle_after_done"}, {done_a, mem_req_a, rom_ce_a, cpu_rst_a}, 4'b1000);
    cycles = n;
  endtask

  initial begin
    int cyc, st, nb, wb;
    bit found;
    logic [17:0] ab;
    logic [31:0] db;

    foreach (rom[i]) rom[i] = $urandom;

    tv[0]  = '{H, L, L,  L, L, H, L, 10'd0, 18'h3FC00, H, 32'h0};
    tv[1]  = '{H, L, L,  L, L, H, L, 10'd0, 18'h3FC00, L, 32'h0};
    tv[2]  = '{L, L, H,  H, L, H, L, 10'd0, 18'h3FC00, L, 32'h0};
    tv[3]  = '{L, L, H,  L, L, H, L, 10'd0, 18'h3FC00, L, 32'h0};
    tv[4]  = '{L, L, L,  L, H, H, L, 10'd0, 18'h3FC00, H, rom[0]};
    tv[5]  = '{L, L, L,  L, H, H, L, 10'd0, 18'h3FC00, H, rom[0]};
    tv[6]  = '{L, L, H,  H, L, H, L, 10'd1, 18'h3FC00, L, 32'h0};
    tv[7]  = '{L, L, H,  L, L, H, L, 10'd1, 18'h3FC00, L, 32'h0};
    tv[8]  = '{L, L, H,  L, H, H, L, 10'd1, 18'h3FC01, H, rom[1]};
    tv[9]  = '{L, H, L,  L, H, H, L, 10'd1, 18'h3FC01, H, rom[1]};
    tv[10] = '{H, L, L,  L, L, H, L, 10'd0, 18'h3FC00, H, 32'h0};

    for (int i = 0; i < 11; i++) begin
      reset_a   = tv[i].rst;
      reload_a  = tv[i].rld;
      mem_ack_a = tv[i].ack;
      tick();
      chk($sformatf("row%0d.rom_ce", i), rom_ce_a, tv[i].ce);
      chk($sformatf("row%0d.rom_oce", i), rom_oce_a, tv[i].ce);
      chk($sformatf("row%0d.rom_reset", i), rom_reset_a, tv[i].rst);
      chk($sformatf("row%0d.mem_req", i), mem_req_a, tv[i].req);
      chk($sformatf("row%0d.cpu_rst", i), cpu_rst_a, tv[i].crst);
      chk($sformatf("row%0d.done", i), done_a, tv[i].dn);
      chk($sformatf("row%0d.rom_ad", i), rom_ad_a, tv[i].ad);
      chk($sformatf("row%0d.mem_addr", i), mem_addr_a, tv[i].addr);
      if (tv[i].wchk) chk($sformatf("row%0d.mem_wdata", i), mem_wdata_a, tv[i].wd);
    end
    reload_a = 1'b0;

    // Plain full copy with ack tied high
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    run_copy("basic", -1, 0, -1, 0, cyc, st);
    chk("basic.cycles_3073", cyc, 3073);

    // Reload from DONE, then re-copy with a 5-cycle stall on word 7 and an ignored reload at word 50
    reload_a = 1'b1;
    tick();
    chk("reload.cpu_rst", cpu_rst_a, 1);
    chk("reload.done", done_a, 0);
`ifdef BOOT_ROM_CKSUM_EN
    chk("reload.cksum_cleared", cksum_a, 0);
`endif
    run_copy("recopy_stall", 7, 5, 50, 0, cyc, st);
    chk("recopy_stall.stall_cycles", st, 5);
    chk("recopy_stall.cycles", cyc, 3078);

    // Reset while the write for word 100 is pending
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (mem_req_a && mem_addr_a == BASE + 18'd100) begin
        mem_ack_a = 1'b0;
        reset_a   = 1'b1;
        tick();
        found = 1;
        break;
      end
      mem_ack_a = 1'b1;
      tick();
    end
    chk("rst100.reached_word", found, 1);
    chk("rst100.mem_req", mem_req_a, 0);
    chk("rst100.cpu_rst", cpu_rst_a, 1);
    chk("rst100.mem_addr", mem_addr_a, BASE);
    chk("rst100.mem_wdata", mem_wdata_a, 0);
    chk("rst100.rom_ce", rom_ce_a, 0);
    reset_a = 1'b0;
    run_copy("rst100_restart", -1, 0, -1, 0, cyc, st);

    // Random ROM contents and random ack (also toggled while no request is pending)
    foreach (rom[i]) rom[i] = $urandom;
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    run_copy("random_ack", -1, 0, -1, 1, cyc, st);

`ifdef BOOT_ROM_CKSUM_EN
    foreach (rom[i]) rom[i] = 32'h1;
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    run_copy("cksum_ones", -1, 0, -1, 0, cyc, st);
    chk("cksum_ones.value", cksum_a, 32'h400);
`endif

    // Single-word instance at 0x3FFFF (and the two-word checksum instance)
    rom[0] = 32'hFFFFFFFF;
    rom[1] = 32'hFFFFFFFF;
    tick();
    reset_b = 1'b0;
    nb = 0;
    wb = 0;
    ab = '0;
    db = '0;
    while (nb < 50) begin
      if (mem_req_b) begin
        wb++;
        ab = mem_addr_b;
        db = mem_wdata_b;
      end
      tick();
      nb++;
      if (done_b) break;
    end
    chk("single.done_cycle", nb, 4);
    chk("single.cpu_rst", cpu_rst_b, 0);
    chk("single.write_count", wb, 1);
    chk("single.mem_addr", ab, 18'h3FFFF);
    chk("single.mem_wdata", db, 32'hFFFFFFFF);
`ifdef BOOT_ROM_CKSUM_EN
    chk("single.cksum", cksum_b, 32'hFFFFFFFF);
    repeat (5) tick();
    chk("cksum_wrap.done", done_c, 1);
    chk("cksum_wrap.value", cksum_c, 32'hFFFFFFFE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boot_rom_shadow_loader.md
Name: boot_rom_shadow_loader

Overview:
- Boot-time copier that sits directly downstream of the 1K x 32 boot pROM in the Next186 SoC.
- After reset it walks the ROM word by word and writes each 32-bit word into main memory at the top of the 1 MB map, so the 80186 reset vector (FFFF0h) lands in RAM.
- It holds the CPU in reset until the copy completes.
- A reload pulse re-runs the copy without a full system reset.

Parameters:
- ROM_AW, 10, ROM word-address width.
- NWORDS, 1024, number of words copied; legal range 1..2^ROM_AW.
- DAW, 18, memory word-address width (32-bit words, 1 MB space).
- DEST_BASE, 18'h3FC00, memory word address of ROM word 0 (byte address FF000h).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- reload  in  1  single-cycle pulse requesting a re-copy; honoured only in DONE.
- rom_ce  out  1  ROM clock enable / read strobe.
- rom_oce  out  1  ROM output enable; equal to rom_ce.
- rom_reset  out  1  ROM output-register reset; equal to reset.
- rom_ad  out  ROM_AW  ROM word address.
- rom_dout  in  32  ROM read data, valid the cycle after rom_ce is sampled high (bypass read mode).
- mem_req  out  1  write request to the memory arbiter.
- mem_ack  in  1  write accepted; handshake completes in any cycle where mem_req and mem_ack are both 1.
- mem_addr  out  DAW  memory word address.
- mem_wdata  out  32  write data.
- cpu_rst  out  1  CPU reset hold; 1 until the copy is done.
- done  out  1  copy complete.

Behaviour:
- Reset values:
  - State IDLE, word index 0.
  - rom_ce 0, rom_ad 0, mem_req 0, mem_addr DEST_BASE, mem_wdata 0.
  - cpu_rst 1, done 0.
- IDLE: unconditionally moves to RD on the next clock.
- RD:
  - rom_ce = 1, rom_ad = index.
  - Next state CAP.
- CAP:
  - rom_ce = 0.
  - Register rom_dout into mem_wdata.
  - Set mem_addr = DEST_BASE + index, truncated to DAW bits.
  - Set mem_req = 1. Next state WR.
- WR:
  - mem_req, mem_addr and mem_wdata are held stable until mem_ack = 1. No ROM reads occur while waiting.
  - On ack with index == NWORDS-1: mem_req drops next cycle and the state moves to DONE.
  - On ack otherwise: index increments and the state moves to RD.
- DONE:
  - done = 1 and cpu_rst = 0, both registered.
  - On reload = 1 the next cycle has cpu_rst = 1, done = 0, index = 0 and state IDLE.
- Throughput: 3 cycles per word with mem_ack tied high. With reset released at cycle 0, done rises at cycle 3*NWORDS+1.
- reload outside DONE is ignored and not queued.
- Reset mid-copy: the next cycle shows reset values (mem_req drops even without ack). The copy restarts from word 0 after reset is released; the arbiter must tolerate an abandoned request.
- mem_ack while mem_req = 0 is ignored.
- NWORDS = 1 gives one word and done at cycle 4.
- The index counter never exceeds NWORDS-1.

Optional Feature:
- Macro: BOOT_ROM_CKSUM_EN.
- When defined:
  - Adds output cksum[31:0].
  - cksum is cleared on reset and on entry to IDLE.
  - cksum accumulates mem_wdata modulo 2^32 on each accepted write.
  - cksum is stable from done onward.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Reset 2 cycles, mem_ack tied 1, NWORDS=1024 → first write mem_addr=0x3FC00 with ROM word 0; last write mem_addr=0x3FFFF; done and cpu_rst=0 at cycle 3073; exactly 1024 writes with data matching the ROM model.
- mem_ack held 0 for 5 cycles on word 7 → mem_addr=0x3FC07 and mem_wdata stable throughout; no rom_ce pulses during the stall; done delayed by exactly 5 cycles.
- Pulse reload in DONE → cpu_rst=1 and done=0 the next cycle; full re-copy of identical data. Pulse reload at word 50 → no effect on the sequence or completion time.
- Assert reset while WR is pending on word 100 → mem_req=0 the next cycle; after release the copy restarts at mem_addr 0x3FC00.
- NWORDS=1, DEST_BASE=18'h3FFFF → a single write at 0x3FFFF; done at cycle 4.
- With BOOT_ROM_CKSUM_EN and every ROM word = 0x00000001, NWORDS=1024 → cksum=0x00000400 at done. With every word = 0xFFFFFFFF and NWORDS=2 → cksum=0xFFFFFFFE (wrap).
